// File: rtl/rei_pkg.sv
// rtl/rei_pkg.sv - shared register indices, widths and UART state type
//
// Purpose: constants and types shared by the dbus UART transmitter and its
//          helpers. No ports.
package rei_pkg;

   localparam logic [1:0] UART_TXDATA_IDX = 2'd0;
   localparam logic [1:0] UART_STATUS_IDX = 2'd1;
   localparam logic [1:0] UART_DIV_IDX    = 2'd2;

   localparam int UART_DIV_WIDTH = 16;

   // PARITY is only entered when UART_PARITY_EN is defined.
   typedef enum logic [2:0] {
      UART_IDLE   = 3'd0,
      UART_START  = 3'd1,
      UART_DATA   = 3'd2,
      UART_PARITY = 3'd3,
      UART_STOP   = 3'd4
   } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO
//
// Purpose: small synchronous FIFO; rdata presents the head entry combinationally.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push, wdata    write request and data (ignored while full)
//   pop            read request (ignored while empty)
//   rdata          head entry, valid while !empty
//   full, empty    occupancy flags
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // Extra MSB is the wrap bit distinguishing full from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/dbus_uart_tx.sv
// rtl/dbus_uart_tx.sv - memory-mapped UART transmitter on the data bus
//
// Purpose: stores to TXDATA queue bytes in a TX FIFO; a serializer sends them
//          as 8N1 frames (8E1 when the macro UART_PARITY_EN is defined) at
//          DIV clocks per bit.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   wvalid_i, awaddr_i, wdata_i,   write port, one cycle per store,
//   wstrb_i                        word index awaddr_i[3:2]
//   araddr_i, rdata_o              read port, rdata_o registered (1-cycle latency)
//   tx_o                           serial line, idles high
//   irq_o                          FIFO empty and serializer idle
// Registers (word index): 0 TXDATA (wo), 1 STATUS, 2 DIV[15:0], 3 reserved.
module dbus_uart_tx #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_RESET  = 868
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    wvalid_i,
   input  logic [ADDR_WIDTH-1:0]   awaddr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic [DATA_WIDTH/8-1:0] wstrb_i,
   input  logic [ADDR_WIDTH-1:0]   araddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    tx_o,
   output logic                    irq_o
);

   import rei_pkg::*;

`ifdef UART_PARITY_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   localparam logic [UART_DIV_WIDTH-1:0] DIV_RST_V = UART_DIV_WIDTH'(DIV_RESET);

   logic [1:0]                wr_idx;
   logic                      txdata_wr;
   logic                      ovf_clr;
   logic                      push;
   logic                      pop;
   logic                      full;
   logic                      empty;
   logic [7:0]                fifo_rdata;
   logic                      overflow_q;
   logic [UART_DIV_WIDTH-1:0] div_q;
   logic [UART_DIV_WIDTH-1:0] reload;
   uart_state_e               state_q;
   logic [7:0]                shift_q;
   logic [2:0]                bit_cnt_q;
   logic [UART_DIV_WIDTH-1:0] baud_cnt_q;
   logic                      parity_q;
   logic                      bit_end;
   logic                      busy;
   logic [DATA_WIDTH-1:0]     status_w;
   logic                      unused_bits;

   assign unused_bits = ^{awaddr_i[ADDR_WIDTH-1:4], awaddr_i[1:0], araddr_i[ADDR_WIDTH-1:4],
                          araddr_i[1:0], wdata_i[DATA_WIDTH-1:16], wstrb_i[DATA_WIDTH/8-1:2]};

   assign wr_idx    = awaddr_i[3:2];
   assign txdata_wr = wvalid_i & wstrb_i[0] & (wr_idx == UART_TXDATA_IDX);
   assign ovf_clr   = wvalid_i & wstrb_i[0] & (wr_idx == UART_STATUS_IDX) & wdata_i[3];
   // Full is judged before the edge, so a same-cycle pop never rescues a push.
   assign push      = txdata_wr & ~full;

   // DIV of 0 behaves as 1: reload value is DIV-1 clamped at 0.
   assign reload  = (div_q == '0) ? '0 : div_q - {{(UART_DIV_WIDTH-1){1'b0}}, 1'b1};
   assign bit_end = (baud_cnt_q == '0);
   assign busy    = (state_q != UART_IDLE);
   // Pop when leaving IDLE, or at the end of a stop bit for a gapless next frame.
   assign pop     = ~empty & ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bit_end));

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(FIFO_DEPTH)
   ) u_tx_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (push),
      .pop   (pop),
      .wdata (wdata_i[7:0]),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
         div_q      <= DIV_RST_V;
      end else begin
         // A same-cycle overflow takes priority over a clear.
         if (txdata_wr && full) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
         if (wvalid_i && (wr_idx == UART_DIV_IDX)) begin
            if (wstrb_i[0]) div_q[7:0]  <= wdata_i[7:0];
            if (wstrb_i[1]) div_q[15:8] <= wdata_i[15:8];
         end
      end
   end

   // tx_o is a flop with async set, so reset forces the line high immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= UART_IDLE;
         tx_o       <= 1'b1;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         baud_cnt_q <= '0;
         parity_q   <= 1'b0;
      end else if (state_q == UART_IDLE) begin
         if (!empty) begin
            state_q    <= UART_START;
            shift_q    <= fifo_rdata;
            parity_q   <= ^fifo_rdata;
            tx_o       <= 1'b0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= reload;
         end
      end else if (!bit_end) begin
         baud_cnt_q <= baud_cnt_q - {{(UART_DIV_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         // Reload samples div_q here, so a DIV write never shortens the current bit.
         baud_cnt_q <= reload;
         case (state_q)
            UART_START: begin
               state_q <= UART_DATA;
               tx_o    <= shift_q[0];
            end
            UART_DATA: begin
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_PARITY_EN
                  state_q <= UART_PARITY;
                  tx_o    <= parity_q;
`else
                  state_q <= UART_STOP;
                  tx_o    <= 1'b1;
`endif
               end else begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  shift_q   <= {1'b0, shift_q[7:1]};
                  tx_o      <= shift_q[1];
               end
            end
`ifdef UART_PARITY_EN
            UART_PARITY: begin
               state_q <= UART_STOP;
               tx_o    <= 1'b1;
            end
`endif
            UART_STOP: begin
               if (!empty) begin
                  state_q   <= UART_START;
                  shift_q   <= fifo_rdata;
                  parity_q  <= ^fifo_rdata;
                  tx_o      <= 1'b0;
                  bit_cnt_q <= '0;
               end else begin
                  state_q <= UART_IDLE;
               end
            end
            default: begin
               state_q <= UART_IDLE;
               tx_o    <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      status_w    = '0;
      status_w[0] = full;
      status_w[1] = empty;
      status_w[2] = busy;
      status_w[3] = overflow_q;
      status_w[4] = PARITY_EN;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_o <= '0;
         irq_o   <= 1'b1;
      end else begin
         irq_o <= empty & ~busy;
         case (araddr_i[3:2])
            UART_STATUS_IDX: rdata_o <= status_w;
            UART_DIV_IDX:    rdata_o <= {{(DATA_WIDTH-UART_DIV_WIDTH){1'b0}}, div_q};
            default:         rdata_o <= '0;
         endcase
      end
   end

endmodule
